cpu_clock_controller: RTL and testbench
=======================================

// Module: cpu_clock_controller
// PURPOSE
//  Run/halt/single-step sequencer for the Galetron CPU clock. Owns a runtime-loadable divisor.
//  Produces a divided square clock (ClkOut) and a one-cycle tick enable (TickEn) per CPU cycle.
//  Sits between board clock/buttons/CPU HLT and the CPU core. Stops only on a low ClkOut phase (no runt pulses).
// PARAMETERS
//  DIV_W        13    width of divisor register and half-period counter
//  DIV_DEFAULT  2500  half-period in Clk cycles after reset; must fit DIV_W, >=2
// PORTS
//  Clk      in   1      board clock; all state on posedge Clk
//  Rst      in   1      reset, asynchronous, active-low (0 = reset)
//  RunReq   in   1      level; request free-running mode
//  HaltReq  in   1      level; request stop (user)
//  CpuHalt  in   1      level; CPU executed HLT, same effect as HaltReq
//  StepReq  in   1      level; request exactly one CPU clock period from HALT
//  DivLoad  in   1      divisor load request, held high until DivAck
//  DivVal   in   DIV_W  new half-period, sampled when DivAck is issued
//  DivAck   out  1      one-cycle pulse: DivVal accepted
//  ClkOut   out  1      divided CPU clock, period 2*DivReg Clk cycles
//  TickEn   out  1      one-cycle pulse in the cycle ClkOut rises
//  State    out  2      current FSM state
// BEHAVIOUR
//  Reset (async, Rst=0): State=HALT, DivReg=DIV_DEFAULT, DivCnt=0, ClkOut=0, TickEn=0, DivAck=0.
//   Rst asserted mid-period forces ClkOut=0 immediately. No ack for a pending DivLoad.
//  States: HALT=0, RUN=1, STEP=2, STOP=3. Request priority each cycle: (HaltReq|CpuHalt) > RunReq > StepReq.
//  Counter: in RUN/STEP/STOP, DivCnt increments each Clk. At DivCnt==DivReg-1 (terminal): DivCnt<=0, ClkOut<=~ClkOut.
//   TickEn<=1 only when that toggle is 0->1. In HALT, DivCnt is held at 0, ClkOut=0, TickEn=0.
//  HALT: RunReq -> RUN; else StepReq -> STEP. Halt requests keep HALT. Counting starts the cycle after entry.
//   First rising ClkOut is exactly DivReg cycles after the entering edge.
//  RUN: halt request with ClkOut=0 -> HALT next cycle, DivCnt<=0, no further rise.
//   Halt request with ClkOut=1 -> STOP. RunReq/StepReq ignored.
//  STEP: counts normally. Terminal toggle 1->0 -> HALT. Net effect: one TickEn, one full ClkOut period.
//   RunReq -> RUN, no counter disturbance. Halt request behaves as in RUN. StepReq ignored (no re-trigger).
//  STOP: counts until terminal toggle 1->0, then HALT. RunReq -> RUN (resume, no glitch). StepReq ignored.
//  StepReq is level: the next step fires only if StepReq is still high once HALT is re-entered.
//   External debounce/edge-detect is the caller's job.
//  Divisor handshake: DivLoad is acked only when State==HALT and no state change occurs that cycle.
//   The cycle after sampling: DivAck=1 for one cycle and DivReg<=max(DivVal,2).
//   DivVal 0 or 1 is clamped to 2. DivLoad outside HALT waits; no ack and DivReg unchanged.
//   DivLoad still high after DivAck starts a new transaction (requester must drop it).
//  All outputs registered. No combinational input->output paths.
// STRUCTURE
//  Shared package galetron_clk_pkg: state encodings S_HALT/S_RUN/S_STEP/S_STOP, DIV_W default, DIV_MIN=2.
//  One sub-module, div_tick_counter: DivCnt + ClkOut phase + TickEn, with inputs en, clr and half-period.
//   The FSM and divisor-handshake logic stay in this module.
// TESTING (DIV_DEFAULT override = 4 unless stated)
//  1 Reset then RunReq=1 -> ClkOut rises 4 cycles later, period 8, TickEn one cycle per rise.
//  2 HALT, StepReq pulse 1 cycle -> exactly one TickEn, ClkOut high 4 cycles, then State=HALT, ClkOut=0.
//  3 RUN, HaltReq while ClkOut=1 with DivCnt=1 -> STOP, ClkOut falls after 2 more cycles, then HALT.
//   Same with ClkOut=0 -> HALT next cycle, no rise.
//  4 HALT, DivLoad=1 DivVal=6 -> DivAck pulse. Subsequent RUN period = 12.
//   DivVal=0 -> period 4 (clamped to 2).
//  5 DivLoad during RUN -> no DivAck. After HaltReq reaches HALT -> DivAck, new divisor applied.
//  6 Rst=0 asynchronously while ClkOut=1 -> ClkOut=0 without Clk edge. After release, all reset values hold.
//   RunReq+HaltReq together -> stays HALT.

Source files
------------

// File: rtl/cpu_clock_controller_pkg.sv
// Shared definitions for the Galetron CPU clock sequencer: state encodings
// and divisor limits.
package galetron_clk_pkg;

  localparam int DIV_W_DEFAULT = 13;
  localparam int DIV_MIN       = 2;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_STOP = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_clock_controller_if.sv
// Request/status bundle between the board-side control logic and the CPU
// clock sequencer.
interface cpu_clock_controller_if
  import galetron_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) ();

  logic             RunReq;
  logic             HaltReq;
  logic             CpuHalt;
  logic             StepReq;
  logic             DivLoad;
  logic [DIV_W-1:0] DivVal;
  logic             DivAck;
  logic             ClkOut;
  logic             TickEn;
  state_t           State;

  modport master (
    output RunReq, HaltReq, CpuHalt, StepReq, DivLoad, DivVal,
    input  DivAck, ClkOut, TickEn, State
  );

  modport slave (
    input  RunReq, HaltReq, CpuHalt, StepReq, DivLoad, DivVal,
    output DivAck, ClkOut, TickEn, State
  );

endinterface

// File: rtl/cpu_clock_controller_div_tick_counter.sv
// Half-period counter producing the divided CPU clock phase and a one-cycle
// tick on each rising phase.
module div_tick_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] half,
  output logic         clk_out,
  output logic         tick,
  output logic         fall
);

  logic [W-1:0] cnt;
  logic         terminal;

  assign terminal = (cnt == half - W'(1));
  // Asserted in the cycle whose closing edge drives the phase from high to low.
  assign fall     = en && terminal && clk_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (en) begin
        if (terminal) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
        end else begin
          cnt <= cnt + W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step sequencer for the Galetron CPU clock with a
// runtime-loadable divisor; stops only on a low clock phase.
module cpu_clock_controller
  import galetron_clk_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DIV_DEFAULT = 2500
) (
  input logic                  Clk,
  input logic                  Rst,
  cpu_clock_controller_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_reg;
  logic             div_ack;
  logic             halt_req;
  logic             accept;
  logic             cnt_en;
  logic             cnt_clr;
  logic             clk_out;
  logic             tick;
  logic             fall;

  assign halt_req = bus.HaltReq | bus.CpuHalt;

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HALT: begin
        if (halt_req)        state_nxt = S_HALT;
        else if (bus.RunReq) state_nxt = S_RUN;
        else if (bus.StepReq) state_nxt = S_STEP;
      end
      S_RUN: begin
        if (halt_req) state_nxt = clk_out ? S_STOP : S_HALT;
      end
      S_STEP: begin
        if (halt_req)        state_nxt = clk_out ? S_STOP : S_HALT;
        else if (bus.RunReq) state_nxt = S_RUN;
        else if (fall)       state_nxt = S_HALT;
      end
      S_STOP: begin
        // A stop that lands on a low phase (entered on the falling edge) ends at once.
        if (!halt_req && bus.RunReq) state_nxt = S_RUN;
        else if (fall || !clk_out)   state_nxt = S_HALT;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  // The counter sits at zero in HALT and is cleared on the edge that enters
  // HALT, so a halt on a low phase can never let a pending rise through.
  assign cnt_en  = (state != S_HALT);
  assign cnt_clr = (state == S_HALT) || (state_nxt == S_HALT);

  // The ack cycle itself is never a sampling cycle, so a held DivLoad yields
  // separate one-cycle pulses rather than a stuck-high ack.
  assign accept = bus.DivLoad && !div_ack && (state == S_HALT) && (state_nxt == S_HALT);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_HALT;
      div_reg <= DIV_W'(DIV_DEFAULT);
      div_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_ack <= accept;
      if (accept) begin
        div_reg <= (bus.DivVal < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.DivVal;
      end
    end
  end

  div_tick_counter #(
    .W (DIV_W)
  ) u_div_tick_counter (
    .clk     (Clk),
    .rst_n   (Rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .half    (div_reg),
    .clk_out (clk_out),
    .tick    (tick),
    .fall    (fall)
  );

  assign bus.DivAck = div_ack;
  assign bus.ClkOut = clk_out;
  assign bus.TickEn = tick;
  assign bus.State  = state;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with DIV_DEFAULT overridden to 4;
// expected waveforms are derived from the half-period arithmetic.
module tb_cpu_clock_controller;
  import galetron_clk_pkg::*;

  localparam int DIV_W = 13;

  logic Clk;
  logic Rst;
  int   vectors;
  int   miscompares;
  int   tick_seen;

  cpu_clock_controller_if #(.DIV_W(DIV_W)) bus ();

  cpu_clock_controller #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (4)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // k counts edges after the edge that entered RUN; half period d.
  task automatic run_expect(input string tag, input int d, input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s_clk_k%0d", tag, k), 32'(bus.ClkOut), 32'((k / d) % 2));
      check($sformatf("%s_tick_k%0d", tag, k), 32'(bus.TickEn), 32'(k % (2 * d) == d));
      check($sformatf("%s_state_k%0d", tag, k), 32'(bus.State), 32'(S_RUN));
    end
  endtask

  task automatic enter_run(input string tag);
    bus.RunReq = 1'b1;
    tick();
    check({tag, "_enter_state"}, 32'(bus.State), 32'(S_RUN));
    check({tag, "_enter_clk"}, 32'(bus.ClkOut), 32'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst         = 1'b0;
    bus.RunReq  = 1'b0;
    bus.HaltReq = 1'b0;
    bus.CpuHalt = 1'b0;
    bus.StepReq = 1'b0;
    bus.DivLoad = 1'b0;
    bus.DivVal  = '0;

    // Reset values
    repeat (3) tick();
    check("rst_state", 32'(bus.State), 32'(S_HALT));
    check("rst_clk", 32'(bus.ClkOut), 32'(0));
    check("rst_tick", 32'(bus.TickEn), 32'(0));
    check("rst_ack", 32'(bus.DivAck), 32'(0));
    Rst = 1'b1;
    tick();
    check("idle_state", 32'(bus.State), 32'(S_HALT));

    // Free run at the default divisor: rise 4 edges after entry, period 8
    enter_run("run4");
    run_expect("run4", 4, 16);

    // CpuHalt on a low phase: HALT next edge, no further rise
    bus.RunReq  = 1'b0;
    bus.CpuHalt = 1'b1;
    tick();
    check("cpuhalt_state", 32'(bus.State), 32'(S_HALT));
    check("cpuhalt_clk", 32'(bus.ClkOut), 32'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("halted_clk%0d", k), 32'(bus.ClkOut), 32'(0));
      check($sformatf("halted_tick%0d", k), 32'(bus.TickEn), 32'(0));
    end
    bus.CpuHalt = 1'b0;

    // Halt on a high phase with DivCnt=1: STOP, fall two edges later, then HALT
    enter_run("stop");
    repeat (5) tick();
    check("stop_pre_clk", 32'(bus.ClkOut), 32'(1));
    bus.RunReq  = 1'b0;
    bus.HaltReq = 1'b1;
    tick();
    check("stop_s1_state", 32'(bus.State), 32'(S_STOP));
    check("stop_s1_clk", 32'(bus.ClkOut), 32'(1));
    tick();
    check("stop_s2_state", 32'(bus.State), 32'(S_STOP));
    check("stop_s2_clk", 32'(bus.ClkOut), 32'(1));
    tick();
    check("stop_end_state", 32'(bus.State), 32'(S_HALT));
    check("stop_end_clk", 32'(bus.ClkOut), 32'(0));
    check("stop_end_tick", 32'(bus.TickEn), 32'(0));
    bus.HaltReq = 1'b0;
    tick();

    // Single step from a one-cycle StepReq pulse
    bus.StepReq = 1'b1;
    tick();
    check("step_enter_state", 32'(bus.State), 32'(S_STEP));
    bus.StepReq = 1'b0;
    tick_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.TickEn) tick_seen++;
      check($sformatf("step_state_k%0d", k), 32'(bus.State), 32'((k < 8) ? S_STEP : S_HALT));
      check($sformatf("step_clk_k%0d", k), 32'(bus.ClkOut), 32'(k >= 4 && k < 8));
    end
    check("step_tick_count", 32'(tick_seen), 32'(1));

    // Divisor load in HALT: DivVal=6 gives period 12
    bus.DivLoad = 1'b1;
    bus.DivVal  = 13'd6;
    tick();
    check("div6_ack", 32'(bus.DivAck), 32'(1));
    check("div6_state", 32'(bus.State), 32'(S_HALT));
    bus.DivLoad = 1'b0;
    tick();
    check("div6_ack_drop", 32'(bus.DivAck), 32'(0));
    enter_run("div6");
    run_expect("div6", 6, 24);

    // DivVal=0 is clamped to 2: period 4
    bus.RunReq  = 1'b0;
    bus.HaltReq = 1'b1;
    tick();
    check("div6_halt_state", 32'(bus.State), 32'(S_HALT));
    bus.DivLoad = 1'b1;
    bus.DivVal  = 13'd0;
    tick();
    check("div0_ack", 32'(bus.DivAck), 32'(1));
    bus.DivLoad = 1'b0;
    bus.HaltReq = 1'b0;
    tick();
    check("div0_ack_drop", 32'(bus.DivAck), 32'(0));
    enter_run("div2");
    run_expect("div2", 2, 8);

    // DivLoad during RUN waits; acked once HALT is reached
    bus.DivLoad = 1'b1;
    bus.DivVal  = 13'd3;
    for (int k = 9; k <= 12; k++) begin
      tick();
      check($sformatf("runload_noack_k%0d", k), 32'(bus.DivAck), 32'(0));
      check($sformatf("runload_clk_k%0d", k), 32'(bus.ClkOut), 32'((k / 2) % 2));
    end
    bus.RunReq  = 1'b0;
    bus.HaltReq = 1'b1;
    tick();
    check("runload_halt_state", 32'(bus.State), 32'(S_HALT));
    check("runload_halt_noack", 32'(bus.DivAck), 32'(0));
    tick();
    check("runload_ack", 32'(bus.DivAck), 32'(1));
    bus.DivLoad = 1'b0;
    bus.HaltReq = 1'b0;
    tick();
    check("runload_ack_drop", 32'(bus.DivAck), 32'(0));
    enter_run("div3");
    run_expect("div3", 3, 10);

    // Asynchronous reset mid-cycle while ClkOut is high
    check("areset_pre_clk", 32'(bus.ClkOut), 32'(1));
    #2;
    Rst = 1'b0;
    #1;
    check("areset_clk", 32'(bus.ClkOut), 32'(0));
    check("areset_state", 32'(bus.State), 32'(S_HALT));
    check("areset_tick", 32'(bus.TickEn), 32'(0));
    bus.RunReq  = 1'b1;
    bus.HaltReq = 1'b1;
    tick();
    tick();
    Rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("runhalt_state%0d", k), 32'(bus.State), 32'(S_HALT));
      check($sformatf("runhalt_clk%0d", k), 32'(bus.ClkOut), 32'(0));
    end
    bus.HaltReq = 1'b0;
    enter_run("postrst");
    run_expect("postrst", 4, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
